// File: rtl/axi_stream_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI Stream datapath between NumInp inputs.
// Latency: one idle arbitration cycle per packet, then beats pass combinationally while locked.
// Backpressure: only the granted input sees out tready; every other input holds tready low.
//
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   in_req_i/in_rsp_o NumInp input streams (tvalid + payload / tready)
//   out_req_o/out_rsp_i  arbitrated output stream
//   sel_o, locked_o   granted input index and packet-lock flag

package axi_stream_pkt_rr_arbiter_pkg;
  // Default payload layout, used when the instantiating block does not supply its own types.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [0:0]  id;
    logic [0:0]  dest;
    logic [0:0]  user;
  } chan_t;

  typedef struct packed {
    logic  tvalid;
    chan_t t;
  } req_t;

  typedef struct packed {
    logic tready;
  } rsp_t;
endpackage

module axi_stream_pkt_rr_arbiter #(
  parameter int unsigned NumInp  = 4,
  parameter int unsigned IdWidth = 0,
  parameter bit          IdxAsId = 1'b0,
  parameter type axi_stream_req_t = axi_stream_pkt_rr_arbiter_pkg::req_t,
  parameter type axi_stream_rsp_t = axi_stream_pkt_rr_arbiter_pkg::rsp_t,
  localparam int unsigned SelW = $clog2(NumInp)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  axi_stream_req_t in_req_i [NumInp],
  output axi_stream_rsp_t in_rsp_o [NumInp],
  output axi_stream_req_t out_req_o,
  input  axi_stream_rsp_t out_rsp_i,
  output logic [SelW-1:0] sel_o,
  output logic            locked_o
);

  localparam int unsigned IdW = $bits(out_req_o.t.id);

  typedef enum logic {
    Idle,
    Locked
  } state_e;

  state_e            state_q;
  logic [SelW-1:0]   grant_q;
  logic [SelW-1:0]   prio_q;

  logic              any_vld;
  logic [SelW-1:0]   pick;
  logic              active;
  logic              last_hs;

  // Round-robin scan starting at prio_q. Only registered state and the tvalid
  // vector feed this, so no tvalid ever reaches a tready.
  always_comb begin
    any_vld = 1'b0;
    pick    = prio_q;
    for (int unsigned k = 0; k < NumInp; k++) begin
      logic [SelW-1:0] cand;
      cand = SelW'((32'(prio_q) + k) % NumInp);
      if (!any_vld && in_req_i[cand].tvalid) begin
        any_vld = 1'b1;
        pick    = cand;
      end
    end
  end

  // Reset gates the outputs immediately so a mid-packet reset truncates at once.
  assign active  = (state_q == Locked) && !rst_i;
  assign last_hs = in_req_i[grant_q].tvalid && out_rsp_i.tready && in_req_i[grant_q].t.last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      case (state_q)
        Idle: begin
          if (any_vld) begin
            grant_q <= pick;
            state_q <= Locked;
          end
        end
        Locked: begin
          // Grant is only released by the tlast handshake; source gaps keep the lock.
          if (last_hs) begin
            prio_q  <= (grant_q == SelW'(NumInp - 1)) ? '0 : grant_q + 1'b1;
            state_q <= Idle;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  always_comb begin
    out_req_o = '0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      in_rsp_o[k] = '0;
    end
    if (active) begin
      out_req_o = in_req_i[grant_q];
      if (IdxAsId) begin
        out_req_o.t.id = IdW'(grant_q);
      end
      in_rsp_o[grant_q].tready = out_rsp_i.tready;
    end
  end

  assign sel_o    = active ? grant_q : '0;
  assign locked_o = active;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    assert (NumInp >= 2);
    assert (!IdxAsId || (IdWidth >= SelW));
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
                   (out_req_o.tvalid && !out_rsp_i.tready) |=> $stable(out_req_o.t));
`endif

endmodule

// File: tb/tb_axi_stream_pkt_rr_arbiter.sv
// Bench for the packet round-robin arbiter: directed scenarios plus randomized packets vs a packet-order model.
// Latency: checks the one-cycle arbitration bubble and beat-by-beat pass-through while locked.
// Backpressure: random and patterned out tready, plus mid-packet source gaps.
module tb_axi_stream_pkt_rr_arbiter;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  strb;
    logic [1:0]  keep;
    logic        last;
    logic [1:0]  id;
    logic [1:0]  dest;
    logic [0:0]  user;
  } chan_t;

  typedef struct packed {
    logic  tvalid;
    chan_t t;
  } req_t;

  typedef struct packed {
    logic tready;
  } rsp_t;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  req_t       in_req [N];
  rsp_t       in_rsp0 [N];
  rsp_t       in_rsp1 [N];
  req_t       out0, out1;
  rsp_t       out_rsp;
  logic [1:0] sel0, sel1;
  logic       lk0, lk1;

  always #5 clk = ~clk;

  // Pass-through id instance and index-as-id instance, fed the same stimulus.
  axi_stream_pkt_rr_arbiter #(
    .NumInp(N), .IdWidth(2), .IdxAsId(1'b0),
    .axi_stream_req_t(req_t), .axi_stream_rsp_t(rsp_t)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .in_req_i(in_req), .in_rsp_o(in_rsp0),
    .out_req_o(out0), .out_rsp_i(out_rsp), .sel_o(sel0), .locked_o(lk0)
  );

  axi_stream_pkt_rr_arbiter #(
    .NumInp(N), .IdWidth(2), .IdxAsId(1'b1),
    .axi_stream_req_t(req_t), .axi_stream_rsp_t(rsp_t)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .in_req_i(in_req), .in_rsp_o(in_rsp1),
    .out_req_o(out1), .out_rsp_i(out_rsp), .sel_o(sel1), .locked_o(lk1)
  );

  int n_chk = 0;
  int n_pass = 0;

  chan_t src_q [N][$];
  chan_t ref_q [N][$];
  logic  mid [N];

  // Observations taken 1ns after the falling edge, away from the active edge.
  logic         o_vld, o_lk, o_lk1, o_rdy, o_hs;
  logic [1:0]   o_sel, o_sel1;
  chan_t        o_t, o_t1;
  logic [N-1:0] o_trdy, o_trdy1;

  task automatic step(input logic rdy, input logic [N-1:0] hold, input logic rst_v);
    logic [N-1:0] acc;
    @(negedge clk);
    rst = rst_v;
    for (int i = 0; i < N; i++) begin
      in_req[i].tvalid = (src_q[i].size() > 0) && !hold[i];
      in_req[i].t      = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
    out_rsp.tready = rdy;
    #1;
    o_vld  = out0.tvalid;
    o_lk   = lk0;
    o_lk1  = lk1;
    o_sel  = sel0;
    o_sel1 = sel1;
    o_t    = out0.t;
    o_t1   = out1.t;
    o_rdy  = rdy;
    o_hs   = out0.tvalid && rdy;
    for (int i = 0; i < N; i++) begin
      o_trdy[i]  = in_rsp0[i].tready;
      o_trdy1[i] = in_rsp1[i].tready;
      acc[i]     = in_req[i].tvalid && in_rsp0[i].tready;
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) begin
        mid[i] = !src_q[i][0].last;
        void'(src_q[i].pop_front());
      end
    end
  endtask

  task automatic clear_and_reset();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      ref_q[i].delete();
      mid[i] = 1'b0;
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
  endtask

  // id < 0 gives a random tid.
  task automatic add_pkt(input int i, input int len, input int id);
    chan_t c;
    for (int b = 0; b < len; b++) begin
      c.data = 16'($urandom);
      c.strb = 2'($urandom);
      c.keep = 2'($urandom);
      c.last = (b == len - 1);
      c.id   = (id < 0) ? 2'($urandom) : 2'(id);
      c.dest = 2'($urandom);
      c.user = 1'($urandom);
      src_q[i].push_back(c);
      ref_q[i].push_back(c);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      ref_q[i].delete();
      mid[i] = 1'b0;
      add_pkt(i, 3, -1);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, '0, 1'b1);
      n_chk++;
      if (o_vld !== 1'b0 || o_trdy !== '0 || o_lk !== 1'b0 || o_sel !== 2'd0)
        $display("FAIL reset cyc%0d: vld=%b trdy=%b lk=%b sel=%0d, want 0 0000 0 0", c, o_vld, o_trdy, o_lk, o_sel);
      else n_pass++;
    end
    step(1'b1, '0, 1'b0);
    n_chk++;
    if (o_lk !== 1'b0 || o_vld !== 1'b0)
      $display("FAIL reset_release_bubble: lk=%b vld=%b, want 0 0", o_lk, o_vld);
    else n_pass++;
    step(1'b1, '0, 1'b0);
    n_chk++;
    if (o_lk !== 1'b1 || o_sel !== 2'd0 || o_vld !== 1'b1 || o_t !== ref_q[0][0])
      $display("FAIL reset_first_grant: lk=%b sel=%0d vld=%b data=%h, want 1 0 1 %h", o_lk, o_sel, o_vld, o_t.data, ref_q[0][0].data);
    else n_pass++;
  endtask

  task automatic test_contention();
    int k, ph, left;
    clear_and_reset();
    for (int i = 0; i < N; i++) add_pkt(i, 3, -1);
    for (int c = 0; c < 16; c++) begin
      step(1'b1, '0, 1'b0);
      k  = c / 4;
      ph = c % 4;
      n_chk++;
      if (ph == 0) begin
        if (o_lk !== 1'b0 || o_vld !== 1'b0 || o_trdy !== '0)
          $display("FAIL contention cyc%0d: lk=%b vld=%b trdy=%b, want idle", c, o_lk, o_vld, o_trdy);
        else n_pass++;
      end else begin
        if (o_lk !== 1'b1 || o_sel !== 2'(k) || o_vld !== 1'b1 || o_t !== ref_q[k][ph-1] || o_trdy !== (4'b1 << k))
          $display("FAIL contention cyc%0d: lk=%b sel=%0d vld=%b data=%h trdy=%b, want 1 %0d 1 %h %b",
                   c, o_lk, o_sel, o_vld, o_t.data, o_trdy, k, ref_q[k][ph-1].data, 4'b1 << k);
        else n_pass++;
      end
    end
    left = 0;
    for (int i = 0; i < N; i++) left += src_q[i].size();
    n_chk++;
    if (left !== 0) $display("FAIL contention_drain: %0d beats left, want 0", left);
    else n_pass++;
  endtask

  task automatic test_fairness_wrap();
    int e_sel [10];
    int e_beat [10];
    e_sel  = '{-1, 3, 3, -1, 0, 0, -1, 3, 3, -1};
    e_beat = '{ 0, 0, 1,  0, 0, 1,  0, 2, 3,  0};
    clear_and_reset();
    add_pkt(3, 2, -1);
    add_pkt(3, 2, -1);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, '0, 1'b0);
      if (c == 0) add_pkt(0, 2, -1);
      n_chk++;
      if (e_sel[c] < 0) begin
        if (o_lk !== 1'b0) $display("FAIL wrap cyc%0d: lk=%b, want 0", c, o_lk);
        else n_pass++;
      end else begin
        if (o_lk !== 1'b1 || o_sel !== 2'(e_sel[c]) || o_t !== ref_q[e_sel[c]][e_beat[c]])
          $display("FAIL wrap cyc%0d: lk=%b sel=%0d data=%h, want 1 %0d %h",
                   c, o_lk, o_sel, o_t.data, e_sel[c], ref_q[e_sel[c]][e_beat[c]].data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic r [6];
    int   n;
    r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    clear_and_reset();
    add_pkt(2, 4, -1);
    add_pkt(3, 3, -1);
    step(1'b1, '0, 1'b0);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      step(r[c], '0, 1'b0);
      n_chk++;
      if (o_lk !== 1'b1 || o_sel !== 2'd2 || o_vld !== 1'b1 || o_t !== ref_q[2][n] ||
          o_trdy !== (r[c] ? 4'b0100 : 4'b0000))
        $display("FAIL backpressure cyc%0d: lk=%b sel=%0d vld=%b data=%h trdy=%b, want 1 2 1 %h %b",
                 c, o_lk, o_sel, o_vld, o_t.data, o_trdy, ref_q[2][n].data, r[c] ? 4'b0100 : 4'b0000);
      else n_pass++;
      if (r[c]) n++;
    end
    n_chk++;
    if (src_q[2].size() !== 0 || src_q[3].size() !== 3)
      $display("FAIL backpressure_count: in2 left=%0d in3 left=%0d, want 0 3", src_q[2].size(), src_q[3].size());
    else n_pass++;
    step(1'b1, '0, 1'b0);
    n_chk++;
    if (o_lk !== 1'b0) $display("FAIL backpressure_bubble: lk=%b, want 0", o_lk);
    else n_pass++;
    step(1'b1, '0, 1'b0);
    n_chk++;
    if (o_lk !== 1'b1 || o_sel !== 2'd3 || o_t !== ref_q[3][0])
      $display("FAIL backpressure_next: lk=%b sel=%0d, want 1 3", o_lk, o_sel);
    else n_pass++;
  endtask

  task automatic test_source_gap();
    logic h0 [9];
    int   e_sel [9];
    int   e_beat [9];
    logic e_vld [9];
    h0     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    e_sel  = '{-1, 0, 0, 0, 0, 0, 0, -1, 1};
    e_beat = '{ 0, 0, 0, 0, 1, 2, 3,  0, 0};
    e_vld  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    clear_and_reset();
    add_pkt(0, 4, -1);
    add_pkt(1, 2, -1);
    for (int c = 0; c < 9; c++) begin
      step(1'b1, {3'b000, h0[c]}, 1'b0);
      n_chk++;
      if (e_sel[c] < 0) begin
        if (o_lk !== 1'b0 || o_vld !== 1'b0)
          $display("FAIL gap cyc%0d: lk=%b vld=%b, want 0 0", c, o_lk, o_vld);
        else n_pass++;
      end else begin
        if (o_lk !== 1'b1 || o_sel !== 2'(e_sel[c]) || o_vld !== e_vld[c] ||
            o_trdy !== (4'b1 << e_sel[c]) || (e_vld[c] && o_t !== ref_q[e_sel[c]][e_beat[c]]))
          $display("FAIL gap cyc%0d: lk=%b sel=%0d vld=%b trdy=%b, want 1 %0d %b %b",
                   c, o_lk, o_sel, o_vld, o_trdy, e_sel[c], e_vld[c], 4'b1 << e_sel[c]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_idx_as_id();
    logic  e_lk [7];
    int    e_beat [7];
    chan_t e;
    e_lk   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    e_beat = '{0, 0, 1, 2, 0, 3, 0};
    clear_and_reset();
    add_pkt(2, 3, 3);
    add_pkt(2, 1, 3);
    for (int c = 0; c < 7; c++) begin
      step(1'b1, '0, 1'b0);
      n_chk++;
      if (!e_lk[c]) begin
        if (o_lk1 !== 1'b0) $display("FAIL idxid cyc%0d: lk=%b, want 0", c, o_lk1);
        else n_pass++;
      end else begin
        e    = ref_q[2][e_beat[c]];
        e.id = 2'd2;
        if (o_lk1 !== 1'b1 || o_sel1 !== 2'd2 || o_t1 !== e || o_t.id !== 2'd3 || o_trdy1 !== 4'b0100)
          $display("FAIL idxid cyc%0d: lk=%b sel=%0d tid=%0d passthru_tid=%0d, want 1 2 2 3",
                   c, o_lk1, o_sel1, o_t1.id, o_t.id);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    chan_t exp_t [$];
    int    exp_i [$];
    int    nxt [N];
    int    prio, g, pos;
    logic  lst, prev_last;
    logic  rdy;
    logic [N-1:0] hold;
    logic [N-1:0] e_trdy;
    chan_t e1;

    clear_and_reset();
    for (int i = 0; i < N; i++) begin
      int np;
      np = $urandom_range(0, 4);
      for (int p = 0; p < np; p++) add_pkt(i, $urandom_range(1, 5), -1);
      nxt[i] = 0;
    end

    // Packet order: first input with packets left at or after the pointer, pointer then moves past it.
    prio = 0;
    for (int guard = 0; guard < 100; guard++) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (prio + k) % N;
        if (g < 0 && nxt[j] < ref_q[j].size()) g = j;
      end
      if (g < 0) break;
      lst = 1'b0;
      while (!lst) begin
        exp_t.push_back(ref_q[g][nxt[g]]);
        exp_i.push_back(g);
        lst = ref_q[g][nxt[g]].last;
        nxt[g]++;
      end
      prio = (g + 1) % N;
    end

    pos = 0;
    prev_last = 1'b0;
    for (int cyc = 0; cyc < 3000 && pos < exp_t.size(); cyc++) begin
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) hold[i] = mid[i] && ($urandom_range(0, 2) == 0);
      step(rdy, hold, 1'b0);
      if (prev_last) begin
        n_chk++;
        if (o_lk !== 1'b0) $display("FAIL rand_bubble cyc%0d: lk=%b, want 0", cyc, o_lk);
        else n_pass++;
      end
      n_chk++;
      if (!o_lk) begin
        if (o_vld !== 1'b0 || o_trdy !== '0)
          $display("FAIL rand_idle cyc%0d: vld=%b trdy=%b, want 0 0000", cyc, o_vld, o_trdy);
        else n_pass++;
      end else begin
        e_trdy = rdy ? (4'b1 << exp_i[pos]) : 4'b0000;
        if (o_sel !== 2'(exp_i[pos]) || o_trdy !== e_trdy)
          $display("FAIL rand_grant cyc%0d: sel=%0d trdy=%b, want %0d %b", cyc, o_sel, o_trdy, exp_i[pos], e_trdy);
        else n_pass++;
      end
      prev_last = 1'b0;
      if (o_hs) begin
        e1    = exp_t[pos];
        e1.id = 2'(exp_i[pos]);
        n_chk++;
        if (o_t !== exp_t[pos] || o_t1 !== e1)
          $display("FAIL rand_beat %0d: data=%h id=%0d idxid=%0d, want %h %0d %0d",
                   pos, o_t.data, o_t.id, o_t1.id, exp_t[pos].data, exp_t[pos].id, e1.id);
        else n_pass++;
        prev_last = exp_t[pos].last;
        pos++;
      end
    end
    n_chk++;
    if (pos !== exp_t.size()) $display("FAIL rand_complete: beats seen=%0d, want %0d", pos, exp_t.size());
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      in_req[i] = '0;
      mid[i]    = 1'b0;
    end
    out_rsp = '0;
    test_reset();
    test_contention();
    test_fairness_wrap();
    test_backpressure();
    test_source_gap();
    test_idx_as_id();
    for (int r = 0; r < 4; r++) test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_stream_pkt_rr_arbiter.md
Name: axi_stream_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXI Stream datapath, such as a dw downsizer or upsizer input, between NumInp requesting streams.
- Grants one input at a time and holds the grant until the tlast beat completes its handshake, so packets never interleave.
- Sits directly in front of the shared datapath block. The same struct-typed req/rsp interface is used on every port.

Parameters:
- NumInp, 4, number of input streams; must be >= 2.
- IdWidth, 0, tid width of req_t.
- IdxAsId, 0, if 1, out tid carries the granted input index (zero-extended); requires IdWidth >= $clog2(NumInp).
- axi_stream_req_t, logic, request struct (tvalid + t.{data,strb,keep,last,id,dest,user}).
- axi_stream_rsp_t, logic, response struct (tready).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_req_i  in  NumInp x axi_stream_req_t  input stream requests.
- in_rsp_o  out  NumInp x axi_stream_rsp_t  input stream responses.
- out_req_o  out  axi_stream_req_t  arbitrated output request.
- out_rsp_i  in  axi_stream_rsp_t  output response.
- sel_o  out  $clog2(NumInp)  index of granted input; valid while locked_o = 1.
- locked_o  out  1  a packet grant is active.

Behaviour:
- States: Idle, Locked. Registers: state_q, grant_q (index), prio_q (round-robin pointer), all reset by rst_i.
- Reset values: state Idle, grant_q 0, prio_q 0. Outputs during and after reset: out tvalid 0, every in tready 0, sel_o 0, locked_o 0. out t fields 0 while Idle.
- Idle:
  - out tvalid 0; all in tready 0.
  - If any in tvalid is set, pick the first valid index scanning prio_q, prio_q+1, … mod NumInp.
  - Load grant_q with that index and go to Locked on the next edge.
  - This gives a 1-cycle arbitration bubble per packet. Grant choice depends only on registered state and the current tvalid vector.
- Locked:
  - out_req_o.tvalid and out_req_o.t are taken from in_req_i[grant_q].
  - in_rsp_o[grant_q].tready = out_rsp_i.tready; all other in tready are 0.
  - sel_o = grant_q; locked_o = 1.
  - If IdxAsId = 1, out t.id = grant_q; otherwise pass through.
- Packet end: on a handshake (out tvalid & out tready) with t.last = 1:
  - prio_q <= (grant_q + 1) mod NumInp (wraps NumInp-1 -> 0).
  - state <= Idle.
- Non-last handshakes and stalls (tvalid without tready, or tvalid dropped by the source mid-packet) keep the Locked state and the grant. A source dropping tvalid mid-packet does not release the grant.
- Single-beat packet (tlast on the first beat): Locked lasts exactly one cycle if out tready = 1.
- No combinational path from in tvalid to any in tready. The only path to in tready is out tready, so the stream is back-pressure transparent.
- Simultaneous requests: lowest index at or after prio_q wins. A continuously requesting input waits at most NumInp-1 packets.
- Reset mid-packet: return to Idle immediately. The partial packet is truncated downstream; upstream is responsible for flushing.
- Assertions (sim only):
  - NumInp >= 2.
  - IdxAsId implies IdWidth >= $clog2(NumInp).
  - Out t stable while out tvalid & !out tready.

Test Plan:
- Reset: assert rst_i 3 cycles with all in tvalid = 1 -> out tvalid 0, all tready 0, locked_o 0. First grant is to input 0, visible 2 cycles after release.
- Contention: NumInp = 4, inputs 0..3 each send one 3-beat packet, all tvalid from cycle 0, out tready = 1 -> grant order 0, 1, 2, 3. Each packet is 3 consecutive beats followed by 1 idle cycle. Total 16 cycles, no interleaving.
- Fairness wrap: input 3 granted, then inputs 3 and 0 both request -> input 0 wins next, then 3. prio_q goes 3 -> 0 -> 1.
- Back-pressure: out tready toggles 1,0,0,1 mid-packet -> out data held stable during stall. Only the granted tready follows out tready; beat count preserved.
- Source gap: granted input drops tvalid 2 cycles mid-packet while input 1 requests -> grant not lost, input 1 waits until tlast handshake.
- IdxAsId = 1, IdWidth = 2: input 2 sends packet with tid 3 -> out tid = 2 on every beat. Single-beat tlast packet -> locked_o high exactly 1 cycle.
